// File: rtl/new_step2.sv
// new_step2 -- multicycle datapath slice of the 16-bit core.
//
// Holds the instruction register, a 16x16 register file, the immediate
// generator, the A/B operand registers, the ALU and the ALUOut register.
// The control FSM drives every select/enable. Every stage is registered, so
// a result appears two clocks after the instruction is captured.
//
// Ports:
//   CLK          in  1   rising-edge clock
//   reset        in  1   asynchronous active-low reset (clears IR, A, B, ALUOut)
//   instruction  in  16  instruction word loaded into IR
//   IRWrite      in  1   IR load enable
//   writeEnable  in  1   register-file write enable (address = IR[11:8])
//   dataWrite    in  16  register-file write data
//   PC           in  16  program counter, alternate ALU A operand
//   ALUSrcA      in  1   0 = PC, 1 = A register
//   ALUSrcB      in  1   0 = B register, 1 = immediate
//   ALUOp        in  3   ALU function
//   numBits      in  2   immediate field select
//   immShift     in  2   immediate left-shift select
//   ALUOut       out 16  ALUOut register (signed)
//   A            out 16  A register
//   B            out 16  B register
//   Op           out 4   IR[15:12]
module new_step2 (
  input  logic               CLK,
  input  logic               reset,
  input  logic [15:0]        instruction,
  input  logic               IRWrite,
  input  logic               writeEnable,
  input  logic [15:0]        dataWrite,
  input  logic [15:0]        PC,
  input  logic               ALUSrcA,
  input  logic               ALUSrcB,
  input  logic [2:0]         ALUOp,
  input  logic [1:0]         numBits,
  input  logic [1:0]         immShift,
  output logic signed [15:0] ALUOut,
  output logic [15:0]        A,
  output logic [15:0]        B,
  output logic [3:0]         Op
);

  logic [15:0] ir_r;
  logic [15:0] aReg_r;
  logic [15:0] bReg_r;
  logic [15:0] aluOut_r;
  logic [15:0] regFile_r [16];

  logic [3:0]  readAddr1_s;
  logic [15:0] readData1_s;
  logic [15:0] readData2_s;
  logic [15:0] immExt_s;
  logic [15:0] imm_s;
  logic [15:0] srcA_s;
  logic [15:0] srcB_s;
  logic [15:0] aluResult_s;

  // Read port 1 uses the rd field for the 8-bit-immediate format (addi-style).
  always_comb begin
    if (numBits == 2'b10) begin
      readAddr1_s = ir_r[11:8];
    end else begin
      readAddr1_s = ir_r[7:4];
    end
    readData1_s = regFile_r[readAddr1_s];
    readData2_s = regFile_r[ir_r[3:0]];
  end

  // Immediate extension followed by the selectable left shift.
  always_comb begin
    case (numBits)
      2'b00:   immExt_s = {{4{ir_r[11]}}, ir_r[11:0]};
      2'b01:   immExt_s = {{12{ir_r[3]}}, ir_r[3:0]};
      2'b10:   immExt_s = {{8{ir_r[7]}}, ir_r[7:0]};
      2'b11:   immExt_s = {12'h000, ir_r[3:0]};
      default: immExt_s = 16'h0000;
    endcase
    case (immShift)
      2'b00:   imm_s = immExt_s;
      2'b01:   imm_s = {immExt_s[14:0], 1'b0};
      2'b10:   imm_s = {immExt_s[13:0], 2'b00};
      2'b11:   imm_s = {immExt_s[7:0], 8'h00};
      default: imm_s = 16'h0000;
    endcase
  end

  // Operand muxes and the ALU; arithmetic wraps with no flags.
  always_comb begin
    if (ALUSrcA) begin
      srcA_s = aReg_r;
    end else begin
      srcA_s = PC;
    end
    if (ALUSrcB) begin
      srcB_s = imm_s;
    end else begin
      srcB_s = bReg_r;
    end
    case (ALUOp)
      3'b000:  aluResult_s = srcA_s + srcB_s;
      3'b001:  aluResult_s = srcA_s - srcB_s;
      3'b010:  aluResult_s = srcA_s & srcB_s;
      3'b011:  aluResult_s = srcA_s | srcB_s;
      3'b100:  aluResult_s = srcA_s ^ srcB_s;
      3'b101:  aluResult_s = srcA_s << srcB_s[3:0];
      3'b110:  aluResult_s = srcA_s >> srcB_s[3:0];
      3'b111:  aluResult_s = $unsigned($signed(srcA_s) >>> srcB_s[3:0]);
      default: aluResult_s = 16'h0000;
    endcase
  end

  // Register file: no reset, so contents survive a reset pulse.
  always_ff @(posedge CLK) begin
    if (writeEnable) begin
      regFile_r[ir_r[11:8]] <= dataWrite;
    end
  end

  // Pipeline registers: IR is enabled, A/B/ALUOut capture every edge.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ir_r     <= 16'h0000;
      aReg_r   <= 16'h0000;
      bReg_r   <= 16'h0000;
      aluOut_r <= 16'h0000;
    end else begin
      if (IRWrite) begin
        ir_r <= instruction;
      end
      aReg_r   <= readData1_s;
      bReg_r   <= readData2_s;
      aluOut_r <= aluResult_s;
    end
  end

  assign ALUOut = $signed(aluOut_r);
  assign A      = aReg_r;
  assign B      = bReg_r;
  assign Op     = ir_r[15:12];

endmodule

// File: tb/tb_new_step2.sv
module tb_new_step2;

  logic               CLK = 1'b0;
  logic               reset = 1'b0;
  logic [15:0]        instruction = 16'h0000;
  logic               IRWrite = 1'b0;
  logic               writeEnable = 1'b0;
  logic [15:0]        dataWrite = 16'h0000;
  logic [15:0]        PC = 16'h0000;
  logic               ALUSrcA = 1'b0;
  logic               ALUSrcB = 1'b0;
  logic [2:0]         ALUOp = 3'b000;
  logic [1:0]         numBits = 2'b00;
  logic [1:0]         immShift = 2'b00;
  logic signed [15:0] ALUOut;
  logic [15:0]        A;
  logic [15:0]        B;
  logic [3:0]         Op;

  int checks = 0;
  int errors = 0;
  int regModel [16];

  new_step2 dut (
    .CLK(CLK), .reset(reset), .instruction(instruction), .IRWrite(IRWrite),
    .writeEnable(writeEnable), .dataWrite(dataWrite), .PC(PC),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .numBits(numBits),
    .immShift(immShift), .ALUOut(ALUOut), .A(A), .B(B), .Op(Op)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic loadIR(input logic [15:0] instr);
    instruction = instr;
    IRWrite = 1'b1;
    step(1);
    IRWrite = 1'b0;
  endtask

  task automatic writeReg(input int rd, input int val);
    loadIR(16'(rd << 8));
    writeEnable = 1'b1;
    dataWrite = 16'(val);
    step(1);
    writeEnable = 1'b0;
    regModel[rd] = val;
  endtask

  // Immediate from the field rules, using integer arithmetic.
  function automatic int modelImm(input int ir, input int nb, input int sh);
    int v;
    int w;
    bit sgn;
    case (nb)
      0: begin v = ir % 4096; w = 12; sgn = 1'b1; end
      1: begin v = ir % 16;   w = 4;  sgn = 1'b1; end
      2: begin v = ir % 256;  w = 8;  sgn = 1'b1; end
      default: begin v = ir % 16; w = 4; sgn = 1'b0; end
    endcase
    if (sgn && v >= (1 << (w - 1))) v = v - (1 << w);
    v = v * (1 << ((sh == 3) ? 8 : sh));
    return ((v % 65536) + 65536) % 65536;
  endfunction

  function automatic int modelAlu(input int op, input int a, input int b);
    longint r;
    int n;
    int sa;
    n = b % 16;
    case (op)
      0: r = (a + b) % 65536;
      1: r = (a - b + 65536) % 65536;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (longint'(a) * (longint'(1) << n)) % 65536;
      6: r = a / (1 << n);
      default: begin
        sa = (a >= 32768) ? a - 65536 : a;
        sa = sa >>> n;
        r = (sa + 65536) % 65536;
      end
    endcase
    return int'(r);
  endfunction

  initial begin
    int ir, nb, sh, op, pcv, srcA, srcB, expA, expB, addr1;

    // Reset state.
    step(2);
    check("reset_A", A, 16'h0000);
    check("reset_B", B, 16'h0000);
    check("reset_ALUOut", ALUOut, 16'h0000);
    check("reset_Op", {12'h000, Op}, 16'h0000);
    reset = 1'b1;
    step(1);

    writeReg(4, 5);
    writeReg(5, 2);

    // add r0,r4,r5
    ALUSrcA = 1'b1; ALUSrcB = 1'b0; ALUOp = 3'b000; numBits = 2'b00; immShift = 2'b00;
    loadIR(16'h0045);
    step(2);
    check("add_A", A, 16'd5);
    check("add_B", B, 16'd2);
    check("add_ALUOut", ALUOut, 16'd7);
    check("add_Op", {12'h000, Op}, 16'h0000);

    // addi r4,10
    numBits = 2'b10; ALUSrcB = 1'b1;
    loadIR(16'hC40A);
    step(2);
    check("addi_ALUOut", ALUOut, 16'd15);
    check("addi_Op", {12'h000, Op}, 16'h000C);

    // jalr r0,r5,5 with imm shifted by 1
    numBits = 2'b01; immShift = 2'b01;
    loadIR(16'hB055);
    step(2);
    check("jalr_ALUOut", ALUOut, 16'd12);

    // Negative immediate, then zero-extended
    immShift = 2'b00;
    loadIR(16'hB05F);
    step(2);
    check("negimm_ALUOut", ALUOut, 16'd1);
    numBits = 2'b11;
    step(2);
    check("zeimm_ALUOut", ALUOut, 16'd17);

    // Reset mid-computation clears immediately; register file retained.
    numBits = 2'b00; ALUSrcB = 1'b0;
    loadIR(16'h0045);
    reset = 1'b0;
    #1;
    check("midreset_ALUOut", ALUOut, 16'h0000);
    check("midreset_A", A, 16'h0000);
    check("midreset_B", B, 16'h0000);
    check("midreset_Op", {12'h000, Op}, 16'h0000);
    step(1);
    reset = 1'b1;
    loadIR(16'h0045);
    step(2);
    check("rerun_ALUOut", ALUOut, 16'd7);

    // PC operand with immediate shifted by 2
    ALUSrcA = 1'b0; PC = 16'h0100; ALUSrcB = 1'b1; numBits = 2'b01; immShift = 2'b10;
    loadIR(16'hB051);
    step(2);
    check("pc_ALUOut", ALUOut, 16'h0104);

    // sub A - B
    ALUSrcA = 1'b1; ALUSrcB = 1'b0; ALUOp = 3'b001; numBits = 2'b00; immShift = 2'b00;
    loadIR(16'h0045);
    step(2);
    check("sub_ALUOut", ALUOut, 16'd3);

    // Same-cycle write and read: A sees the old value first.
    loadIR(16'h0440);
    writeEnable = 1'b1; dataWrite = 16'd9;
    step(1);
    writeEnable = 1'b0;
    regModel[4] = 9;
    check("wr_rd_old_A", A, 16'd5);
    step(1);
    check("wr_rd_new_A", A, 16'd9);

    // Randomized instructions against the reference model.
    for (int i = 0; i < 40; i++) begin
      writeReg(int'($urandom_range(15, 0)), int'($urandom_range(65535, 0)));
      ir  = int'($urandom_range(65535, 0));
      nb  = int'($urandom_range(3, 0));
      sh  = int'($urandom_range(3, 0));
      op  = int'($urandom_range(7, 0));
      pcv = int'($urandom_range(65535, 0));
      numBits = 2'(nb); immShift = 2'(sh); ALUOp = 3'(op); PC = 16'(pcv);
      ALUSrcA = 1'($urandom_range(1, 0)); ALUSrcB = 1'($urandom_range(1, 0));
      loadIR(16'(ir));
      step(2);
      addr1 = (nb == 2) ? (ir >> 8) % 16 : (ir >> 4) % 16;
      expA = regModel[addr1];
      expB = regModel[ir % 16];
      srcA = ALUSrcA ? expA : pcv;
      srcB = ALUSrcB ? modelImm(ir, nb, sh) : expB;
      check("rand_A", A, 16'(expA));
      check("rand_B", B, 16'(expB));
      check("rand_ALUOut", ALUOut, 16'(modelAlu(op, srcA, srcB)));
      check("rand_Op", {12'h000, Op}, 16'(ir >> 12));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
